tlb_op_ctrl: RTL

- Issue-side controller for the TLB maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Accepts one operation from the commit stage and drives the TLB write, refill, read, search and invalidate ports.
- Samples the TLB's read and search results and returns a one-cycle completion pulse with the result fields for the CSR file.
- Owns the random fill-index counter.

---
 rtl/tlb_pkg.sv | 53 +++++
 rtl/tlb_op_ctrl_if.sv | 78 +++++++
 rtl/tlb_fill_counter.sv | 22 ++
 rtl/tlb_op_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types, widths and op encodings for the TLB maintenance controller
//   no ports; provides op_code constants, INV_IDLE, the packed TLB entry layout,
//   the FSM state type and the INVTLB op legality check.
package tlb_pkg;

    localparam int ENTRY_W  = 88;
    localparam int VPPN_W   = 19;
    localparam int ASID_W   = 10;
    localparam int VA_W     = 32;
    localparam int INV_OP_W = 5;
    localparam int CLR_W    = 3;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    // tlb_clear_mem value meaning "no invalidate in progress"
    localparam logic [CLR_W-1:0] INV_IDLE = 3'd7;

    localparam logic [INV_OP_W-1:0] INV_OP_MAX = 5'd6;

    // MSB to LSB: vpn2, asid, ps, g, then the even and odd page halves
    typedef struct packed {
        logic [18:0] vpn2;
        logic [9:0]  asid;
        logic [5:0]  ps;
        logic        g;
        logic [19:0] pfn0;
        logic [1:0]  mat0;
        logic [1:0]  plv0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [1:0]  mat1;
        logic [1:0]  plv1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // The full 5-bit op is compared: op 13 has low bits 5 but is still illegal
    function automatic logic inv_op_legal(input logic [INV_OP_W-1:0] op);
        return op <= INV_OP_MAX;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// rtl/tlb_op_ctrl_if.sv - commit-side request/response and TLB port bundle for tlb_op_ctrl
//   commit -> ctrl : op_valid, op_code, inv_op/asid/vaddr, csr_index/ne/entry/asid/vppn, refill_mode
//   ctrl -> commit : op_ready, done, res_index(_we), res_ne(_we), res_entry(_we), res_ine
//   ctrl -> TLB    : tlb_we, tlb_fill_mode, tlb_w_index, tlb_f_index, tlb_w_entry, tlb_w_e,
//                    tlb_r_index, tlb_check_mode, tlb_s_vpn2, tlb_s_asid, tlb_clear_*
//   TLB -> ctrl    : tlb_r_entry, tlb_rs_e, tlb_s_index
//   modport slave is the controller; modport master is the commit stage plus TLB.
interface tlb_op_ctrl_if #(
    parameter int TLBNUM = 32
);
    import tlb_pkg::*;

    localparam int IW = $clog2(TLBNUM);

    logic                 op_valid;
    logic                 op_ready;
    logic [2:0]           op_code;
    logic [INV_OP_W-1:0]  inv_op;
    logic [ASID_W-1:0]    inv_asid;
    logic [VA_W-1:0]      inv_vaddr;
    logic [IW-1:0]        csr_index;
    logic                 csr_ne;
    tlb_entry_t           csr_entry;
    logic [ASID_W-1:0]    csr_asid;
    logic [VPPN_W-1:0]    csr_vppn;
    logic                 refill_mode;

    logic                 tlb_we;
    logic                 tlb_fill_mode;
    logic [IW-1:0]        tlb_w_index;
    logic [IW-1:0]        tlb_f_index;
    tlb_entry_t           tlb_w_entry;
    logic                 tlb_w_e;
    logic [IW-1:0]        tlb_r_index;
    logic                 tlb_check_mode;
    logic [VPPN_W-1:0]    tlb_s_vpn2;
    logic [ASID_W-1:0]    tlb_s_asid;
    logic [CLR_W-1:0]     tlb_clear_mem;
    logic [VA_W-1:0]      tlb_clear_vaddr;
    logic [ASID_W-1:0]    tlb_clear_asid;
    tlb_entry_t           tlb_r_entry;
    logic                 tlb_rs_e;
    logic [IW-1:0]        tlb_s_index;

    logic                 done;
    logic                 res_index_we;
    logic [IW-1:0]        res_index;
    logic                 res_ne_we;
    logic                 res_ne;
    logic                 res_entry_we;
    tlb_entry_t           res_entry;
    logic                 res_ine;

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vaddr,
               csr_index, csr_ne, csr_entry, csr_asid, csr_vppn, refill_mode,
               tlb_r_entry, tlb_rs_e, tlb_s_index,
        output op_ready,
               tlb_we, tlb_fill_mode, tlb_w_index, tlb_f_index, tlb_w_entry, tlb_w_e,
               tlb_r_index, tlb_check_mode, tlb_s_vpn2, tlb_s_asid,
               tlb_clear_mem, tlb_clear_vaddr, tlb_clear_asid,
               done, res_index_we, res_index, res_ne_we, res_ne,
               res_entry_we, res_entry, res_ine
    );

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vaddr,
               csr_index, csr_ne, csr_entry, csr_asid, csr_vppn, refill_mode,
               tlb_r_entry, tlb_rs_e, tlb_s_index,
        input  op_ready,
               tlb_we, tlb_fill_mode, tlb_w_index, tlb_f_index, tlb_w_entry, tlb_w_e,
               tlb_r_index, tlb_check_mode, tlb_s_vpn2, tlb_s_asid,
               tlb_clear_mem, tlb_clear_vaddr, tlb_clear_asid,
               done, res_index_we, res_index, res_ne_we, res_ne,
               res_entry_we, res_entry, res_ine
    );

endinterface

// File: rtl/tlb_fill_counter.sv
// rtl/tlb_fill_counter.sv - free-running pseudo-random TLBFILL index counter
//   clk, rstn (async active-low) in; fill_cnt out, IW bits, +1 every cycle.
module tlb_fill_counter #(
    parameter int TLBNUM = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic [$clog2(TLBNUM)-1:0] fill_cnt
);
    localparam int IW = $clog2(TLBNUM);
    localparam logic [IW-1:0] ONE = IW'(1);

    // TLBNUM is a power of two, so natural overflow gives the TLBNUM-1 -> 0 wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_cnt <= '0;
        end else begin
            fill_cnt <= fill_cnt + ONE;
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - issue-side controller for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
//   clk, rstn (async active-low) plain ports; everything else through bus (slave modport).
//   Accepts one op in IDLE, drives the TLB for one EXEC cycle, pulses done in RESP.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 32
) (
    input  logic         clk,
    input  logic         rstn,
    tlb_op_ctrl_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);

    state_t              state;

    // operand registers, loaded at accept
    logic [2:0]          op_q;
    logic [INV_OP_W-1:0] inv_op_q;
    logic [ASID_W-1:0]   inv_asid_q;
    logic [VA_W-1:0]     inv_vaddr_q;
    logic [IW-1:0]       index_q;
    logic                ne_q;
    tlb_entry_t          entry_q;
    logic [ASID_W-1:0]   asid_q;
    logic [VPPN_W-1:0]   vppn_q;
    logic                refill_q;
    logic [IW-1:0]       fill_q;

    // registered TLB strobes and result registers
    logic                tlb_we_q;
    logic                check_q;
    logic [CLR_W-1:0]    clear_q;
    logic                done_q;
    logic                idx_we_q;
    logic [IW-1:0]       res_index_q;
    logic                ne_we_q;
    logic                res_ne_q;
    logic                entry_we_q;
    tlb_entry_t          res_entry_q;
    logic                ine_q;

    logic [IW-1:0]       fill_cnt;

    tlb_fill_counter #(
        .TLBNUM (TLBNUM)
    ) u_fill_counter (
        .clk      (clk),
        .rstn     (rstn),
        .fill_cnt (fill_cnt)
    );

    // Strobes are set on the accept edge so they are high for exactly the EXEC
    // cycle; the async reset clears tlb_we_q, so a reset mid-EXEC aborts the write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            op_q        <= '0;
            inv_op_q    <= '0;
            inv_asid_q  <= '0;
            inv_vaddr_q <= '0;
            index_q     <= '0;
            ne_q        <= 1'b0;
            entry_q     <= '0;
            asid_q      <= '0;
            vppn_q      <= '0;
            refill_q    <= 1'b0;
            fill_q      <= '0;
            tlb_we_q    <= 1'b0;
            check_q     <= 1'b0;
            clear_q     <= INV_IDLE;
            done_q      <= 1'b0;
            idx_we_q    <= 1'b0;
            res_index_q <= '0;
            ne_we_q     <= 1'b0;
            res_ne_q    <= 1'b0;
            entry_we_q  <= 1'b0;
            res_entry_q <= '0;
            ine_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_q        <= bus.op_code;
                        inv_op_q    <= bus.inv_op;
                        inv_asid_q  <= bus.inv_asid;
                        inv_vaddr_q <= bus.inv_vaddr;
                        index_q     <= bus.csr_index;
                        ne_q        <= bus.csr_ne;
                        entry_q     <= bus.csr_entry;
                        asid_q      <= bus.csr_asid;
                        vppn_q      <= bus.csr_vppn;
                        refill_q    <= bus.refill_mode;
                        fill_q      <= fill_cnt;
                        tlb_we_q    <= (bus.op_code == OP_WR) || (bus.op_code == OP_FILL);
                        check_q     <= (bus.op_code == OP_SRCH);
                        clear_q     <= ((bus.op_code == OP_INV) && inv_op_legal(bus.inv_op))
                                       ? bus.inv_op[CLR_W-1:0] : INV_IDLE;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    tlb_we_q <= 1'b0;
                    check_q  <= 1'b0;
                    clear_q  <= INV_IDLE;
                    done_q   <= 1'b1;
                    case (op_q)
                        OP_SRCH: begin
                            ne_we_q  <= 1'b1;
                            res_ne_q <= ~bus.tlb_rs_e;
                            if (bus.tlb_rs_e) begin
                                idx_we_q    <= 1'b1;
                                res_index_q <= bus.tlb_s_index;
                            end
                        end
                        OP_RD: begin
                            // An invalid entry reads back as all-zero fields
                            entry_we_q  <= 1'b1;
                            res_entry_q <= bus.tlb_rs_e ? bus.tlb_r_entry : '0;
                            ne_we_q     <= 1'b1;
                            res_ne_q    <= ~bus.tlb_rs_e;
                        end
                        OP_INV: begin
                            ine_q <= ~inv_op_legal(inv_op_q);
                        end
                        default: ;
                    endcase
                    state <= S_RESP;
                end
                S_RESP: begin
                    done_q     <= 1'b0;
                    idx_we_q   <= 1'b0;
                    ne_we_q    <= 1'b0;
                    entry_we_q <= 1'b0;
                    ine_q      <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready        = (state == S_IDLE);

    assign bus.tlb_we          = tlb_we_q;
    assign bus.tlb_fill_mode   = (op_q == OP_FILL);
    assign bus.tlb_w_index     = index_q;
    assign bus.tlb_f_index     = fill_q;
    assign bus.tlb_w_entry     = entry_q;
    // refill handler writes a valid entry even when TLBIDX.NE is set
    assign bus.tlb_w_e         = refill_q | ~ne_q;
    assign bus.tlb_r_index     = index_q;
    assign bus.tlb_check_mode  = check_q;
    assign bus.tlb_s_vpn2      = vppn_q;
    assign bus.tlb_s_asid      = asid_q;
    assign bus.tlb_clear_mem   = clear_q;
    assign bus.tlb_clear_vaddr = inv_vaddr_q;
    assign bus.tlb_clear_asid  = inv_asid_q;

    assign bus.done            = done_q;
    assign bus.res_index_we    = idx_we_q;
    assign bus.res_index       = res_index_q;
    assign bus.res_ne_we       = ne_we_q;
    assign bus.res_ne          = res_ne_q;
    assign bus.res_entry_we    = entry_we_q;
    assign bus.res_entry       = res_entry_q;
    assign bus.res_ine         = ine_q;

endmodule
